// File: rtl/mic_capture_ctrl_if.sv
// Capture/drain handshake bundle between the mic capture sequencer and its FIFO/UART/I2S neighbours.
interface mic_capture_ctrl_if #(
    parameter int unsigned CNT_W = 15
);
    logic             sample_vld;
    logic             fifo_full;
    logic             fifo_empty;
    logic             tx_ready;
    logic             fifo_wr_en;
    logic             fifo_rd_en;
    logic             tx_ena;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] sample_cnt;
    logic [1:0]       state;

    // Sequencer side
    modport master (
        input  sample_vld, fifo_full, fifo_empty, tx_ready,
        output fifo_wr_en, fifo_rd_en, tx_ena, busy, done, overflow, sample_cnt, state
    );

    // Environment side
    modport slave (
        output sample_vld, fifo_full, fifo_empty, tx_ready,
        input  fifo_wr_en, fifo_rd_en, tx_ena, busy, done, overflow, sample_cnt, state
    );
endinterface

// File: rtl/mic_capture_ctrl.sv
// Mic capture sequencer: debounced start/abort keys, NUM_SAMPLES-frame FIFO write
// window, then FIFO drain to the UART over the ena/ready handshake.
module mic_capture_ctrl #(
    parameter int unsigned NUM_SAMPLES  = 16384,
    parameter int unsigned CNT_W        = 15,
    parameter int unsigned DEBOUNCE_CYC = 600000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                key_start_n,
    input  logic                key_abort_n,
    mic_capture_ctrl_if.master  bus
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // index 0: start key, index 1: abort key
    logic [1:0]      key_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic             ovf_q, ovf_n;
    logic             wr_q, wr_n;
    logic             done_q, done_n;
    logic             busy_q, busy_n;
    logic             start_evt, abort_evt;
    logic             tx_ena_c;

    assign key_raw   = {key_abort_n, key_start_n};
    assign start_evt = press[0];
    assign abort_evt = press[1];
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Synchronise both keys and accept a level only after it has held DEBOUNCE_CYC cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            stable <= 2'b11;
            press  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            ovf_q   <= ovf_n;
            wr_q    <= wr_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
        end
    end

    // Next state; abort overrides everything and leaves counters untouched
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ovf_n   = ovf_q;
        wr_n    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    state_n = ST_CAPTURE;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (bus.sample_vld) begin
                    wr_n  = ~bus.fifo_full;
                    cnt_n = cnt_inc;
                    if (bus.fifo_full) begin
                        ovf_n = 1'b1;
                    end
                    if (cnt_inc == CNT_LAST) begin
                        state_n = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.fifo_empty && !bus.tx_ready) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (abort_evt) begin
            state_n = ST_IDLE;
            cnt_n   = cnt_q;
            ovf_n   = ovf_q;
            wr_n    = 1'b0;
        end
        done_n = (state_n == ST_DONE);
        busy_n = (state_n == ST_CAPTURE) || (state_n == ST_DRAIN);
    end

    // Drain handshake is combinational so a tx_ready pulse pops in the same cycle
    assign tx_ena_c = (state_q == ST_DRAIN) && !bus.fifo_empty;

    assign bus.tx_ena     = tx_ena_c;
    assign bus.fifo_rd_en = tx_ena_c && bus.tx_ready;
    assign bus.fifo_wr_en = wr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Bench for mic_capture_ctrl: directed scenarios plus random traffic, all outputs
// checked every cycle against a behavioural model of the capture sequencer.
module tb_mic_capture_ctrl;

    localparam int unsigned NUM = 8;
    localparam int unsigned CW  = 4;
    localparam int unsigned DEB = 4;

    logic sys_clk     = 1'b0;
    logic sys_rst_n   = 1'b0;
    logic key_start_n = 1'b1;
    logic key_abort_n = 1'b1;

    mic_capture_ctrl_if #(.CNT_W(CW)) bus ();

    mic_capture_ctrl #(
        .NUM_SAMPLES (NUM),
        .CNT_W       (CW),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_start_n(key_start_n),
        .key_abort_n(key_abort_n),
        .bus        (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_state = 0;
    int m_cnt   = 0;
    bit m_ovf   = 1'b0;
    bit m_wr    = 1'b0;
    bit ev_s    = 1'b0;
    bit ev_a    = 1'b0;
    bit acc_s   = 1'b1;
    bit acc_a   = 1'b1;
    bit hs[$];
    bit ha[$];
    bit m_rd;
    bit m_nwr;

    // environment FIFO occupancy
    int level = 0;
    int depth = 16;

    // pulse totals seen on the DUT outputs
    int wr_total   = 0;
    int rd_total   = 0;
    int done_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // A key level is accepted once the last DEB synchronised samples all disagree with the accepted level
    function automatic bit window_flip(input bit h[$], input bit acc);
        for (int i = 0; i < int'(DEB); i++) begin
            if (h[i] == acc) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Behavioural model of the sequencer plus the FIFO occupancy of the environment
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_state = 0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_wr    = 1'b0;
            ev_s    = 1'b0;
            ev_a    = 1'b0;
            acc_s   = 1'b1;
            acc_a   = 1'b1;
            hs.delete();
            ha.delete();
            repeat (DEB + 1) begin
                hs.push_back(1'b1);
                ha.push_back(1'b1);
            end
        end else begin
            m_rd  = bus.tx_ready && (m_state == 2) && !bus.fifo_empty;
            level = level + int'(m_wr) - int'(m_rd);
            if (level < 0) level = 0;
            m_nwr = 1'b0;
            if (ev_a) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: if (ev_s) begin
                        m_state = 1;
                        m_cnt   = 0;
                        m_ovf   = 1'b0;
                    end
                    1: if (bus.sample_vld) begin
                        m_nwr = !bus.fifo_full;
                        if (bus.fifo_full) m_ovf = 1'b1;
                        m_cnt = m_cnt + 1;
                        if (m_cnt == int'(NUM)) m_state = 2;
                    end
                    2: if (bus.fifo_empty && !bus.tx_ready) m_state = 3;
                    default: m_state = 0;
                endcase
            end
            m_wr = m_nwr;
            ev_s = 1'b0;
            if (window_flip(hs, acc_s)) begin
                acc_s = !acc_s;
                ev_s  = !acc_s;
            end
            ev_a = 1'b0;
            if (window_flip(ha, acc_a)) begin
                acc_a = !acc_a;
                ev_a  = !acc_a;
            end
            hs.push_back(key_start_n);
            void'(hs.pop_front());
            ha.push_back(key_abort_n);
            void'(ha.pop_front());
        end
    end

    // Every cycle: compare all outputs with the model, just before the next active edge
    always @(negedge sys_clk) begin
        #2;
        chk("state",      int'(bus.state),      m_state);
        chk("busy",       int'(bus.busy),       int'(m_state == 1 || m_state == 2));
        chk("done",       int'(bus.done),       int'(m_state == 3));
        chk("fifo_wr_en", int'(bus.fifo_wr_en), int'(m_wr));
        chk("tx_ena",     int'(bus.tx_ena),     int'(m_state == 2 && !bus.fifo_empty));
        chk("fifo_rd_en", int'(bus.fifo_rd_en), int'(m_state == 2 && !bus.fifo_empty && bus.tx_ready));
        chk("sample_cnt", int'(bus.sample_cnt), m_cnt);
        chk("overflow",   int'(bus.overflow),   int'(m_ovf));
        wr_total   += int'(bus.fifo_wr_en);
        rd_total   += int'(bus.fifo_rd_en);
        done_total += int'(bus.done);
    end

    task automatic tick();
        @(negedge sys_clk);
        bus.sample_vld = 1'b0;
        bus.tx_ready   = 1'b0;
        bus.fifo_empty = (level == 0);
        bus.fifo_full  = (level >= depth);
    endtask

    task automatic press(input bit abort_key, input int low_cyc);
        if (abort_key) key_abort_n = 1'b0; else key_start_n = 1'b0;
        repeat (low_cyc) tick();
        if (abort_key) key_abort_n = 1'b1; else key_start_n = 1'b1;
        repeat (DEB + 6) tick();
    endtask

    task automatic capture(input int n, input int gap, input int full_at);
        for (int i = 1; i <= n; i++) begin
            repeat (gap - 1) tick();
            tick();
            bus.sample_vld = 1'b1;
            if (i == full_at) bus.fifo_full = 1'b1;
        end
        repeat (2) tick();
    endtask

    task automatic drain_to_idle(input string nm);
        int n;
        n = 0;
        while (bus.state != 2'd0 && n < 400) begin
            tick();
            n++;
            if (n % 20 == 0) bus.tx_ready = 1'b1;
        end
        chk(nm, int'(bus.state), 0);
    endtask

    int w0, r0, d0, hold_s, hold_a;

    initial begin
        bus.sample_vld = 1'b0;
        bus.tx_ready   = 1'b0;
        bus.fifo_full  = 1'b0;
        bus.fifo_empty = 1'b1;

        // reset values
        repeat (3) tick();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_cnt",   int'(bus.sample_cnt), 0);
        chk("rst_ovf",   int'(bus.overflow), 0);
        #3 sys_rst_n = 1'b1;

        // short glitch is filtered, a long press starts a run
        tick();
        key_start_n = 1'b0;
        repeat (3) tick();
        key_start_n = 1'b1;
        repeat (15) tick();
        chk("short_press_idle", int'(bus.state), 0);
        press(1'b0, 10);
        chk("start_state", int'(bus.state), 1);
        chk("start_busy",  int'(bus.busy), 1);

        // run A: FIFO full during frame 3
        w0 = wr_total;
        capture(8, 32, 3);
        chk("runA_cnt",   int'(bus.sample_cnt), 8);
        chk("runA_state", int'(bus.state), 2);
        chk("runA_ovf",   int'(bus.overflow), 1);
        chk("runA_writes", wr_total - w0, 7);
        tick();
        bus.sample_vld = 1'b1;
        repeat (3) tick();
        chk("ninth_vld_no_write", wr_total - w0, 7);
        r0 = rd_total;
        d0 = done_total;
        drain_to_idle("runA_idle");
        chk("runA_reads", rd_total - r0, 7);
        chk("runA_done",  done_total - d0, 1);
        chk("runA_ovf_held", int'(bus.overflow), 1);

        // run B: clean capture of 8 frames, drained with tx_ready every 20 cycles
        press(1'b0, 10);
        chk("runB_ovf_cleared", int'(bus.overflow), 0);
        chk("runB_cnt_cleared", int'(bus.sample_cnt), 0);
        w0 = wr_total;
        capture(8, 32, 0);
        chk("runB_writes", wr_total - w0, 8);
        r0 = rd_total;
        d0 = done_total;
        drain_to_idle("runB_idle");
        chk("runB_reads", rd_total - r0, 8);
        chk("runB_done",  done_total - d0, 1);

        // abort after frame 4; start during capture is ignored
        press(1'b0, 10);
        capture(4, 8, 0);
        press(1'b0, 10);
        chk("restart_ignored_state", int'(bus.state), 1);
        chk("restart_ignored_cnt",   int'(bus.sample_cnt), 4);
        d0 = done_total;
        press(1'b1, 10);
        chk("abort_state", int'(bus.state), 0);
        chk("abort_cnt",   int'(bus.sample_cnt), 4);
        chk("abort_no_done", done_total - d0, 0);

        // async reset in the middle of a drain
        press(1'b0, 10);
        capture(8, 8, 0);
        repeat (2) begin
            repeat (19) tick();
            tick();
            bus.tx_ready = 1'b1;
        end
        tick();
        #3 sys_rst_n = 1'b0;
        #1;
        chk("arst_state",  int'(bus.state), 0);
        chk("arst_busy",   int'(bus.busy), 0);
        chk("arst_wr",     int'(bus.fifo_wr_en), 0);
        chk("arst_tx_ena", int'(bus.tx_ena), 0);
        chk("arst_cnt",    int'(bus.sample_cnt), 0);
        repeat (3) tick();
        #3 sys_rst_n = 1'b1;
        press(1'b0, 10);
        chk("fresh_state", int'(bus.state), 1);
        chk("fresh_cnt",   int'(bus.sample_cnt), 0);
        press(1'b1, 10);

        // random traffic, keys included
        depth  = 6;
        hold_s = 0;
        hold_a = 40;
        for (int c = 0; c < 4000; c++) begin
            tick();
            bus.sample_vld = ($urandom_range(0, 3) == 0);
            bus.tx_ready   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) bus.fifo_full = 1'b1;
            if (hold_s == 0) begin
                key_start_n = ~key_start_n;
                hold_s = key_start_n ? int'($urandom_range(5, 30)) : int'($urandom_range(1, 12));
            end else begin
                hold_s--;
            end
            if (hold_a == 0) begin
                key_abort_n = ~key_abort_n;
                hold_a = key_abort_n ? int'($urandom_range(20, 150)) : int'($urandom_range(1, 10));
            end else begin
                hold_a--;
            end
        end
        key_start_n = 1'b1;
        key_abort_n = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
